muxn1_arb: RTL and testbench
============================

# muxn1_arb

Parametrised N:1 multiplexer with a registered output and valid/ready flow control on every input channel and on the output. The channel is chosen by an external selector (directed mode) or by a round-robin arbiter over the channels that have data. It replaces the fixed 2:1, 2-bit registered mux in datapaths that need more channels, wider data or backpressure. It sits between several producer channels and one consumer.

## Interface
- `WIDTH`, default 2: data bits per channel.
- `NUM_CH`, default 4: number of input channels, 2..16.
- `SEL_W`, derived localparam = clog2(NUM_CH): selector and grant width.
- `clk` input 1: rising-edge clock; the only clock.
- `reset` input 1: synchronous, active-high reset.
- `mode` input 1: 0 = directed by `selector`, 1 = round-robin.
- `selector` input SEL_W: channel index used in directed mode.
- `data_in` input NUM_CH*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
- `valid_in` input NUM_CH: per-channel data valid.
- `ready_in` output NUM_CH: per-channel accept. Combinational; at most one bit is high.
- `data_out` output WIDTH: registered output data.
- `valid_out` output 1: `data_out` holds an item.
- `ready_out` input 1: consumer accepts the item.
- `grant_out` output SEL_W: registered index of the channel that supplied `data_out`.
- `sel_err` output 1: sticky flag. Set when `selector` ≥ NUM_CH in directed mode while any `valid_in` bit is high.

## Operation
- **Output register.** One entry: `data_out`, `grant_out`, `valid_out`.
- **Load enable.** `load_en = !valid_out || ready_out`.
- **Directed mode (mode=0).**
  - Candidate channel is `selector`.
  - `ready_in[selector] = load_en`.
  - If `selector` ≥ NUM_CH, all `ready_in` bits are 0 and no transfer occurs.
- **Round-robin mode (mode=1).**
  - Candidate is the first c with `valid_in[c]` high, searching c = ptr, ptr+1, …, wrapping modulo NUM_CH.
  - `ready_in[candidate] = load_en`. If no channel is valid, all `ready_in` bits are 0.
- **Accept.** A transfer happens when `valid_in[c] && ready_in[c]`. On the next edge:
  - `data_out` ← channel c data;
  - `grant_out` ← c;
  - `valid_out` ← 1.
- **Pop without accept.** If `ready_out && valid_out` and no accept occurs, `valid_out` ← 0. `data_out` and `grant_out` keep their values.
- **Simultaneous pop and accept.** The new item replaces the old one in the same edge. `valid_out` stays 1, so throughput is 1 item per cycle.
- **Round-robin pointer.**
  - `ptr` (SEL_W bits) ← (c+1) mod NUM_CH on every accept made in round-robin mode.
  - Accepts in directed mode do not change `ptr`.
  - The wrap from NUM_CH-1 goes to 0, including when NUM_CH is not a power of 2.
- **Mode switch.** Takes effect in the same cycle, since selection is combinational. `ptr` is retained across switches.
- **`sel_err`.** Cleared only by `reset`.
- **`valid_in` without `ready_in`.** Producers must hold data. The block never drops an item that has been accepted.

## Timing
- **Reset values.** `data_out`=0, `valid_out`=0, `grant_out`=0, `sel_err`=0, `ptr`=0. All `ready_in` bits are 0 during the reset cycle.
- **Reset mid-operation.** A held output item is discarded. No accept occurs in a cycle where `reset`=1.
- **Latency.** 1 cycle from the accept edge to `valid_out`=1.
- **Combinational paths.** `valid_in`, `selector`, `mode` and `ready_out` feed `ready_in` combinationally. There is no path from input data to output data.
- **Fairness.** In round-robin mode with all channels continuously valid and `ready_out`=1, grants cycle 0,1,…,NUM_CH-1,0…. Each channel waits at most NUM_CH-1 accepts.

## Configuration
- Macro: `MUXN1_ARB_RR_EN`.
- **Defined.** Round-robin mode and `ptr` are implemented as described above.
- **Undefined.**
  - The `mode` input is ignored and operation is always directed.
  - No `ptr` register is built.
  - Area matches a plain registered N:1 mux with handshake.
- All other behaviour is identical in both builds.

## Test plan
- **Reset.** Hold `reset`=1 for 2 cycles with all inputs active → `valid_out`=0, `data_out`=0, `grant_out`=0, `ready_in`=0. Release and drive directed `selector`=2, `valid_in`=4'b0100, ch2=2'b11 → next cycle `data_out`=2'b11, `grant_out`=2, `valid_out`=1.
- **Backpressure.** Directed mode, `ready_out`=0 with an item held → `ready_in`=0 and the item is unchanged for 5 cycles. Raise `ready_out` with new valid data → the new item is loaded on the same edge and `valid_out` stays 1.
- **Round-robin rotation.** Round-robin, NUM_CH=4, all valid, `ready_out`=1 → `grant_out` sequence 0,1,2,3,0. Then `valid_in`=4'b1001 with `ptr`=1 → grant 3, then 0.
- **Non-power-of-2 width.** NUM_CH=3, round-robin, all valid → grants 0,1,2,0 with no grant 3. Directed `selector`=3 with valid data → no transfer, `sel_err`=1 and it stays 1 until reset.
- **Reset mid-operation.** Round-robin with `ptr`=2 and a held item; assert `reset` for 1 cycle → `valid_out`=0. The next round-robin grant with all channels valid is 0.
- **Build without macro.** Compile without `MUXN1_ARB_RR_EN`, `mode`=1, `selector`=1, all valid → every grant is 1.

Source files
------------

// File: rtl/muxn1_arb.sv
// muxn1_arb: N:1 multiplexer with a one-entry registered output and
// valid/ready handshaking on every input channel and on the output.
// The channel is picked by an external selector (directed mode) or, when the
// design is built with MUXN1_ARB_RR_EN defined, by a round-robin arbiter over
// the channels that currently present data (mode=1).
// Without MUXN1_ARB_RR_EN the mode input is ignored and no pointer is built.
module muxn1_arb #(
    parameter int  WIDTH  = 2,
    parameter int  NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        selector,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]       valid_in,
    output logic [NUM_CH-1:0]       ready_in,
    output logic [WIDTH-1:0]        data_out,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [SEL_W-1:0]        grant_out,
    output logic                    sel_err
);

    // Channel count at selector width + 1 so out-of-range selectors compare correctly.
    localparam logic [SEL_W:0] NUM_CH_W = NUM_CH[SEL_W:0];

    // Output register and sticky error flag
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;

    logic              load_en;
    logic              sel_in_range;
    logic              rr_mode;
    logic [SEL_W-1:0]  cand;
    logic              cand_ok;
    logic [NUM_CH-1:0] hit;
    logic              cand_valid;
    logic              accept;
    logic              err_set;
    logic [WIDTH-1:0]  cand_data;

    // The output slot can take a new item when empty or being drained this cycle.
    assign load_en      = !valid_q || ready_out;
    assign sel_in_range = ({1'b0, selector} < NUM_CH_W);

`ifdef MUXN1_ARB_RR_EN
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [2*NUM_CH-1:0] valid_dbl;
    logic [SEL_W-1:0]    rr_off;
    logic                rr_found;
    logic [SEL_W:0]      rr_sum;
    logic [SEL_W-1:0]    rr_cand;
    logic [SEL_W:0]      cand_inc;

    assign rr_mode   = mode;
    // Two copies back to back let the scan from ptr wrap without modulo logic.
    assign valid_dbl = {valid_in, valid_in};

    // Find the smallest offset from ptr whose channel is valid, then map it
    // back to a channel index, wrapping at NUM_CH (not at 2**SEL_W).
    always_comb begin
        rr_found = 1'b0;
        rr_off   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (valid_dbl[k + int'(ptr_q)]) begin
                rr_found = 1'b1;
                rr_off   = SEL_W'(k);
            end
        end
        rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
        if (rr_sum >= NUM_CH_W) begin
            rr_sum = rr_sum - NUM_CH_W;
        end
        rr_cand = SEL_W'(rr_sum);
    end

    assign cand    = rr_mode ? rr_cand  : selector;
    assign cand_ok = rr_mode ? rr_found : sel_in_range;

    // Pointer moves just past the granted channel on round-robin accepts only.
    always_comb begin
        ptr_d    = ptr_q;
        cand_inc = {1'b0, cand} + 1'b1;
        if (cand_inc == NUM_CH_W) begin
            cand_inc = '0;
        end
        if (accept && rr_mode) begin
            ptr_d = SEL_W'(cand_inc);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign rr_mode     = 1'b0;
    assign cand        = selector;
    assign cand_ok     = sel_in_range;
`endif

    // One-hot decode of the candidate; ready goes only to that channel.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign hit[gi]      = cand_ok && (cand == SEL_W'(gi));
        assign ready_in[gi] = hit[gi] && load_en && !reset;
    end

    assign cand_valid = |(hit & valid_in);
    assign accept     = cand_valid && load_en && !reset;
    assign err_set    = !rr_mode && !sel_in_range && (|valid_in);

    // AND-OR mux of the candidate channel's data
    always_comb begin
        cand_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cand_data = cand_data | (data_in[c*WIDTH +: WIDTH] & {WIDTH{hit[c]}});
        end
    end

    // Output slot next state: load on accept, otherwise drain on ready_out.
    always_comb begin
        data_d  = data_q;
        grant_d = grant_q;
        valid_d = valid_q;
        if (accept) begin
            data_d  = cand_data;
            grant_d = cand;
            valid_d = 1'b1;
        end else if (ready_out) begin
            valid_d = 1'b0;
        end
        err_d = err_q | err_set;
    end

    // Output register and sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_out  = data_q;
    assign grant_out = grant_q;
    assign valid_out = valid_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_muxn1_arb.sv
// Bench for muxn1_arb: two instances (4 channels x 2 bits, 3 channels x 3 bits)
// driven by a directed vector table, hand sequences and random stimulus, all
// compared against a behavioural model. Follows MUXN1_ARB_RR_EN if defined.
module tb_muxn1_arb;

`ifdef MUXN1_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       a_mode, a_vout, a_rout, a_err;
    logic [1:0] a_sel, a_dout, a_gout;
    logic [7:0] a_din;
    logic [3:0] a_vin, a_rin;

    logic       b_mode, b_vout, b_rout, b_err;
    logic [1:0] b_sel, b_gout;
    logic [8:0] b_din;
    logic [2:0] b_vin, b_rin, b_dout;

    muxn1_arb #(.WIDTH(2), .NUM_CH(4)) u_dut_a (
        .clk(clk), .reset(reset), .mode(a_mode), .selector(a_sel),
        .data_in(a_din), .valid_in(a_vin), .ready_in(a_rin),
        .data_out(a_dout), .valid_out(a_vout), .ready_out(a_rout),
        .grant_out(a_gout), .sel_err(a_err)
    );

    muxn1_arb #(.WIDTH(3), .NUM_CH(3)) u_dut_b (
        .clk(clk), .reset(reset), .mode(b_mode), .selector(b_sel),
        .data_in(b_din), .valid_in(b_vin), .ready_in(b_rin),
        .data_out(b_dout), .valid_out(b_vout), .ready_out(b_rout),
        .grant_out(b_gout), .sel_err(b_err)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit v;
        int data;
        int grant;
        int ptr;
        bit err;
    } mst_t;

    mst_t ma, mb;

    // Channel that sees ready_in high this cycle, or -1.
    function automatic int m_ready_idx(mst_t s, int n, bit md, int sel, int vbits, bit rout, bit rst);
        if (rst || !(!s.v || rout)) return -1;
        if (RR && md) begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (s.ptr + k) % n;
                if (vbits[c]) return c;
            end
            return -1;
        end
        if (sel >= n) return -1;
        return sel;
    endfunction

    function automatic mst_t m_next(mst_t s, int n, int w, bit md, int sel, int vbits,
                                    int din, bit rout, bit rst);
        mst_t r;
        int c;
        r = s;
        if (rst) begin
            r.v = 0; r.data = 0; r.grant = 0; r.ptr = 0; r.err = 0;
            return r;
        end
        c = m_ready_idx(s, n, md, sel, vbits, rout, rst);
        if (!(RR && md) && sel >= n && vbits != 0) r.err = 1;
        if (c >= 0 && vbits[c]) begin
            r.v = 1;
            r.data = (din >> (c * w)) & ((1 << w) - 1);
            r.grant = c;
            if (RR && md) r.ptr = (c + 1) % n;
        end else if (s.v && rout) begin
            r.v = 0;
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    logic [3:0] a_rin_s;
    logic [2:0] b_rin_s;

    // One clock: check ready_in mid-cycle, advance the model, check registers.
    task automatic tick();
        int   ia, ib;
        mst_t na, nb;
        @(negedge clk);
        a_rin_s = a_rin;
        b_rin_s = b_rin;
        ia = m_ready_idx(ma, 4, a_mode, int'(a_sel), int'(a_vin), a_rout, reset);
        ib = m_ready_idx(mb, 3, b_mode, int'(b_sel), int'(b_vin), b_rout, reset);
        chk("a_ready_in", 32'(a_rin), ia >= 0 ? (1 << ia) : 0);
        chk("b_ready_in", 32'(b_rin), ib >= 0 ? (1 << ib) : 0);
        na = m_next(ma, 4, 2, a_mode, int'(a_sel), int'(a_vin), int'(a_din), a_rout, reset);
        nb = m_next(mb, 3, 3, b_mode, int'(b_sel), int'(b_vin), int'(b_din), b_rout, reset);
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        chk("a_valid_out", 32'(a_vout), int'(ma.v));
        chk("a_data_out",  32'(a_dout), ma.data);
        chk("a_grant_out", 32'(a_gout), ma.grant);
        chk("a_sel_err",   32'(a_err),  int'(ma.err));
        chk("b_valid_out", 32'(b_vout), int'(mb.v));
        chk("b_data_out",  32'(b_dout), mb.data);
        chk("b_grant_out", 32'(b_gout), mb.grant);
        chk("b_sel_err",   32'(b_err),  int'(mb.err));
        $display("t=%0t rst=%0b a: rin=%b vo=%0b do=%0d go=%0d err=%0b | b: rin=%b vo=%0b do=%0d go=%0d err=%0b",
                 $time, reset, a_rin_s, a_vout, a_dout, a_gout, a_err,
                 b_rin_s, b_vout, b_dout, b_gout, b_err);
    endtask

    task automatic set_a(logic md, logic [1:0] sel, logic [3:0] vld, logic [7:0] din, logic rdy);
        a_mode = md; a_sel = sel; a_vin = vld; a_din = din; a_rout = rdy;
    endtask

    task automatic set_b(logic md, logic [1:0] sel, logic [2:0] vld, logic [8:0] din, logic rdy);
        b_mode = md; b_sel = sel; b_vin = vld; b_din = din; b_rout = rdy;
    endtask

    // ---------------- directed vector table (instance a) ----------------
    typedef struct {
        bit       rst;
        bit       md;
        bit [1:0] sel;
        bit [3:0] vld;
        bit [7:0] din;
        bit       rdy;
        bit [3:0] rin;   // expected ready_in before the edge
        bit       vo;    // expected registers after the edge
        bit [1:0] dout;
        bit [1:0] gout;
    } vec_t;

    function automatic vec_t mk(bit rst, bit md, bit [1:0] sel, bit [3:0] vld, bit [7:0] din,
                                bit rdy, bit [3:0] rin, bit vo, bit [1:0] dout, bit [1:0] gout);
        vec_t v;
        v.rst = rst; v.md = md; v.sel = sel; v.vld = vld; v.din = din; v.rdy = rdy;
        v.rin = rin; v.vo = vo; v.dout = dout; v.gout = gout;
        return v;
    endfunction

    vec_t tbl[14];
    int   exp_ga[5] = '{0, 1, 2, 3, 0};
    int   exp_gb[5] = '{0, 1, 2, 0, 1};

    initial begin
        ma = '0;
        mb = '0;
        reset = 1'b1;
        set_a(1'b0, 2'd0, 4'h0, 8'h00, 1'b1);
        set_b(1'b0, 2'd0, 3'b000, 9'h000, 1'b1);

        //            rst  md    sel    vld    din    rdy   rin    vo    dout   gout
        tbl[0]  = mk(1'b1, 1'b0, 2'd2, 4'hF, 8'hFF, 1'b1, 4'h0, 1'b0, 2'd0, 2'd0);
        tbl[1]  = mk(1'b1, 1'b0, 2'd2, 4'hF, 8'hFF, 1'b1, 4'h0, 1'b0, 2'd0, 2'd0);
        tbl[2]  = mk(1'b0, 1'b0, 2'd2, 4'h4, 8'h30, 1'b1, 4'h4, 1'b1, 2'd3, 2'd2);
        tbl[3]  = mk(1'b0, 1'b0, 2'd1, 4'h2, 8'h04, 1'b0, 4'h0, 1'b1, 2'd3, 2'd2);
        tbl[4]  = mk(1'b0, 1'b0, 2'd1, 4'h2, 8'h04, 1'b0, 4'h0, 1'b1, 2'd3, 2'd2);
        tbl[5]  = mk(1'b0, 1'b0, 2'd1, 4'h2, 8'h04, 1'b0, 4'h0, 1'b1, 2'd3, 2'd2);
        tbl[6]  = mk(1'b0, 1'b0, 2'd1, 4'h2, 8'h04, 1'b0, 4'h0, 1'b1, 2'd3, 2'd2);
        tbl[7]  = mk(1'b0, 1'b0, 2'd1, 4'h2, 8'h04, 1'b0, 4'h0, 1'b1, 2'd3, 2'd2);
        tbl[8]  = mk(1'b0, 1'b0, 2'd1, 4'h2, 8'h04, 1'b1, 4'h2, 1'b1, 2'd1, 2'd1);
        tbl[9]  = mk(1'b0, 1'b0, 2'd1, 4'h0, 8'h00, 1'b1, 4'h2, 1'b0, 2'd1, 2'd1);
        tbl[10] = mk(1'b0, 1'b0, 2'd3, 4'h0, 8'h00, 1'b0, 4'h8, 1'b0, 2'd1, 2'd1);
        tbl[11] = mk(1'b0, 1'b0, 2'd0, 4'h1, 8'h02, 1'b0, 4'h1, 1'b1, 2'd2, 2'd0);
        tbl[12] = mk(1'b0, 1'b0, 2'd0, 4'h1, 8'h03, 1'b0, 4'h0, 1'b1, 2'd2, 2'd0);
        tbl[13] = mk(1'b0, 1'b0, 2'd0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b0, 2'd2, 2'd0);

        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst;
            set_a(tbl[i].md, tbl[i].sel, tbl[i].vld, tbl[i].din, tbl[i].rdy);
            set_b(1'b0, 2'd0, 3'b000, 9'h000, 1'b1);
            tick();
            chk($sformatf("tbl%0d_ready_in", i), 32'(a_rin_s), int'(tbl[i].rin));
            chk($sformatf("tbl%0d_valid_out", i), 32'(a_vout), int'(tbl[i].vo));
            chk($sformatf("tbl%0d_data_out", i), 32'(a_dout), int'(tbl[i].dout));
            chk($sformatf("tbl%0d_grant_out", i), 32'(a_gout), int'(tbl[i].gout));
        end

        // Out-of-range selector on the 3-channel instance: no transfer, sticky error.
        reset = 1'b0;
        set_a(1'b0, 2'd0, 4'h0, 8'h00, 1'b1);
        set_b(1'b0, 2'd3, 3'b111, 9'h1FF, 1'b1);
        tick();
        chk("selerr_ready_in", 32'(b_rin_s), 0);
        chk("selerr_valid_out", 32'(b_vout), 0);
        chk("selerr_set", 32'(b_err), 1);
        set_b(1'b0, 2'd0, 3'b001, 9'h005, 1'b1);
        tick();
        chk("selerr_sticky", 32'(b_err), 1);
        chk("selerr_ok_grant", 32'(b_gout), 0);
        chk("selerr_ok_data", 32'(b_dout), 5);
        tick();
        chk("selerr_sticky2", 32'(b_err), 1);
        reset = 1'b1;
        tick();
        chk("selerr_clear", 32'(b_err), 0);
        reset = 1'b0;

`ifdef MUXN1_ARB_RR_EN
        // Rotation with every channel valid on both instances.
        set_a(1'b1, 2'd0, 4'hF, 8'hE4, 1'b1);
        set_b(1'b1, 2'd0, 3'b111, 9'h088, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr_a_grant%0d", i), 32'(a_gout), exp_ga[i]);
            chk($sformatf("rr_a_data%0d", i), 32'(a_dout), exp_ga[i]);
            chk($sformatf("rr_b_grant%0d", i), 32'(b_gout), exp_gb[i]);
        end
        set_b(1'b0, 2'd0, 3'b000, 9'h000, 1'b1);
        // ptr=1 with only channels 0 and 3 valid: 3 first, then wrap to 0.
        set_a(1'b1, 2'd0, 4'h9, 8'hE4, 1'b1);
        tick();
        chk("rr_sparse_g3", 32'(a_gout), 3);
        tick();
        chk("rr_sparse_g0", 32'(a_gout), 0);
        set_a(1'b1, 2'd0, 4'hF, 8'hE4, 1'b1);
        tick();
        chk("rr_pre_g1", 32'(a_gout), 1);
        set_a(1'b1, 2'd0, 4'hF, 8'hE4, 1'b0);
        tick();
        chk("rr_hold_valid", 32'(a_vout), 1);
        chk("rr_hold_grant", 32'(a_gout), 1);
        reset = 1'b1;
        tick();
        chk("rr_midreset_valid", 32'(a_vout), 0);
        reset = 1'b0;
        set_a(1'b1, 2'd0, 4'hF, 8'hE4, 1'b1);
        tick();
        chk("rr_after_reset_g0", 32'(a_gout), 0);
`else
        // Mode input ignored: selector decides every grant.
        set_a(1'b1, 2'd1, 4'hF, 8'hE4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("norr_grant%0d", i), 32'(a_gout), 1);
            chk($sformatf("norr_data%0d", i), 32'(a_dout), 1);
        end
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            set_a(1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
            set_b(1'($urandom), 2'($urandom), 3'($urandom), 9'($urandom),
                  ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
